// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares one combinational-read program ROM between the instruction-fetch
// requester (IF) and the constant-data load requester (DM). At most one
// access is granted per cycle. The ROM address and the returned read data
// are both registered, which gives a fixed two-edge latency from the grant
// cycle to the valid pulse at one access per cycle of throughput.
//
// DM normally wins a contested cycle. A starvation counter tracks how many
// consecutive cycles IF has been refused. Once it reaches STARVE_MAX, IF
// wins the next contested cycle. STARVE_MAX = 0 gives strict DM priority.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   if_req / if_addr    IF request; address held stable until if_gnt
//   if_flush            drop the IF access currently between E0 and E1
//   if_gnt              IF accepted this cycle (combinational)
//   if_valid/if_err     one-cycle result pulse; err qualifies valid
//   if_rdata            IF read data (0 for an errored access)
//   dm_req / dm_addr    DM request; address held stable until dm_gnt
//   dm_gnt              DM accepted this cycle (combinational)
//   dm_valid/dm_err     one-cycle result pulse; err qualifies valid
//   dm_rdata            DM read data (0 for an errored access)
//   rom_addr            registered byte address driven to the ROM
//   rom_data            ROM word, combinational from rom_addr
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int ROM_AW     = 7,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_valid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  // Counter width covers 0..STARVE_MAX and is never narrower than one bit.
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  // With a limit of zero the guard is disabled and DM always wins.
  localparam logic GUARD_EN = (STARVE_MAX > 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // In-flight access descriptor, captured at the grant edge.
  typedef struct packed {
    owner_e owner;
    logic   err;
    logic   valid;
  } tag_t;

  localparam tag_t TAG_IDLE = '{owner: OWN_IF, err: 1'b0, valid: 1'b0};

  // An address is bad if it is not word aligned or lies beyond the ROM.
  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] high_bits;
    high_bits = addr >> (ROM_AW + 2);
    return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
  endfunction

  logic [CW-1:0] starve_cnt_r;
  logic [CW-1:0] starve_cnt_nxt_s;
  logic          if_wins_s;
  logic          if_gnt_s;
  logic          dm_gnt_s;
  logic          gnt_any_s;
  logic [31:0]   gnt_addr_s;
  owner_e        gnt_owner_s;
  tag_t          tag_r;
  logic [31:0]   rom_addr_r;

  logic          deliver_if_s;
  logic          deliver_dm_s;
  logic [31:0]   rdata_s;

  logic          if_valid_r;
  logic          if_err_r;
  logic [31:0]   if_rdata_r;
  logic          dm_valid_r;
  logic          dm_err_r;
  logic [31:0]   dm_rdata_r;

  // Grant selection: one winner per cycle, DM first unless IF has starved.
  always_comb begin
    if_gnt_s  = 1'b0;
    dm_gnt_s  = 1'b0;
    if_wins_s = GUARD_EN && (starve_cnt_r == STARVE_LIM);
    if (if_req && dm_req) begin
      if (if_wins_s) begin
        if_gnt_s = 1'b1;
      end else begin
        dm_gnt_s = 1'b1;
      end
    end else if (dm_req) begin
      dm_gnt_s = 1'b1;
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end
  end

  // Granted address and owner feeding the grant edge.
  always_comb begin
    gnt_any_s   = if_gnt_s || dm_gnt_s;
    gnt_addr_s  = if_addr;
    gnt_owner_s = OWN_IF;
    if (dm_gnt_s) begin
      gnt_addr_s  = dm_addr;
      gnt_owner_s = OWN_DM;
    end else begin
      gnt_addr_s  = if_addr;
      gnt_owner_s = OWN_IF;
    end
  end

  // Starvation counter: count refused IF cycles, saturating at the limit;
  // any IF grant or an idle IF request clears it.
  always_comb begin
    starve_cnt_nxt_s = CNT_ZERO;
    if (if_req && !if_gnt_s) begin
      if (starve_cnt_r == STARVE_LIM) begin
        starve_cnt_nxt_s = starve_cnt_r;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
      end
    end else begin
      starve_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Grant edge: capture ROM address and in-flight tag, update starve count.
  // With no grant the ROM address holds so the ROM input stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_r   <= 32'd0;
      tag_r        <= TAG_IDLE;
      starve_cnt_r <= CNT_ZERO;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      if (gnt_any_s) begin
        rom_addr_r <= gnt_addr_s;
        tag_r      <= '{owner: gnt_owner_s, err: addr_err(gnt_addr_s), valid: 1'b1};
      end else begin
        tag_r      <= TAG_IDLE;
      end
    end
  end

  // Result routing: a flush only kills an IF access that is already in
  // flight; errored accesses still complete but return zero data.
  always_comb begin
    deliver_if_s = 1'b0;
    deliver_dm_s = 1'b0;
    rdata_s      = 32'd0;
    if (tag_r.valid) begin
      case (tag_r.owner)
        OWN_IF:  deliver_if_s = !if_flush;
        OWN_DM:  deliver_dm_s = 1'b1;
        default: begin
          deliver_if_s = 1'b0;
          deliver_dm_s = 1'b0;
        end
      endcase
    end else begin
      deliver_if_s = 1'b0;
      deliver_dm_s = 1'b0;
    end
    if (tag_r.err) begin
      rdata_s = 32'd0;
    end else begin
      rdata_s = rom_data;
    end
  end

  // Data edge: one-cycle valid pulse to the owner; the other port's data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
      if_err_r   <= 1'b0;
      if_rdata_r <= 32'd0;
      dm_valid_r <= 1'b0;
      dm_err_r   <= 1'b0;
      dm_rdata_r <= 32'd0;
    end else begin
      if_valid_r <= deliver_if_s;
      if_err_r   <= deliver_if_s && tag_r.err;
      dm_valid_r <= deliver_dm_s;
      dm_err_r   <= deliver_dm_s && tag_r.err;
      if (deliver_if_s) begin
        if_rdata_r <= rdata_s;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (deliver_dm_s) begin
        dm_rdata_r <= rdata_s;
      end else begin
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

  assign if_gnt   = if_gnt_s;
  assign dm_gnt   = dm_gnt_s;
  assign rom_addr = rom_addr_r;
  assign if_valid = if_valid_r;
  assign if_err   = if_err_r;
  assign if_rdata = if_rdata_r;
  assign dm_valid = dm_valid_r;
  assign dm_err   = dm_err_r;
  assign dm_rdata = dm_rdata_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
//
// Directed testbench for rom_port_arbiter with a scoreboard. The stimulus
// task checks the combinational grant and, for each expected grant, stages
// the expected response; one cycle later (after honouring if_flush) the
// entry moves into a queue. A separate monitor pops and compares whenever
// the DUT raises if_valid or dm_valid.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

  localparam int EXP_NONE = 0;
  localparam int EXP_IF   = 1;
  localparam int EXP_DM   = 2;

  typedef struct packed {
    logic        owner;  // 1 = DM
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_valid;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_gnt;
  logic        dm_valid;
  logic        dm_err;
  logic [31:0] dm_rdata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t stage0;
  logic stage0_v;
  logic [31:0] last_if_rdata;
  logic [31:0] last_dm_rdata;

  rom_port_arbiter #(.ROM_AW(7), .STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_err   (if_err),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_gnt   (dm_gnt),
    .dm_valid (dm_valid),
    .dm_err   (dm_err),
    .dm_rdata (dm_rdata),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 2 is fixed, every other word encodes its index.
  function automatic logic [31:0] rom_word(input logic [6:0] idx);
    if (idx == 7'd2) return 32'h3403FFFF;
    return {16'hC0DE, 9'd0, idx};
  endfunction

  assign rom_data = rom_word(rom_addr[8:2]);

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:9] != 23'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // One stimulus cycle; entered and left at posedge+1.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic fl, input int exp);
    logic [1:0]  exp_gnt;
    logic [31:0] a;
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_addr  = da;
    if_flush = fl;
    @(negedge clk);
    exp_gnt = (exp == EXP_IF) ? 2'b10 : (exp == EXP_DM) ? 2'b01 : 2'b00;
    chk("grant{if,dm}", {30'd0, if_gnt, dm_gnt}, {30'd0, exp_gnt});
    if (stage0_v && !(fl && !stage0.owner)) exp_q.push_back(stage0);
    stage0_v = (exp != EXP_NONE);
    a = (exp == EXP_DM) ? da : ia;
    stage0.owner = (exp == EXP_DM);
    stage0.err   = bad_addr(a);
    stage0.rdata = bad_addr(a) ? 32'd0 : rom_word(a[8:2]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, EXP_NONE);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("rst_if_err", {31'd0, if_err}, 32'd0);
    chk("rst_dm_err", {31'd0, dm_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
  endtask

  // Monitor: compares every result pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("single_valid", {31'd0, if_valid && dm_valid}, 32'd0);
      chk("err_qualified", {31'd0, (if_err && !if_valid) || (dm_err && !dm_valid)}, 32'd0);
      if (if_valid || dm_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got if_valid=%0b dm_valid=%0b expected none at %0t",
                   if_valid, dm_valid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("owner_is_dm", {31'd0, dm_valid}, {31'd0, e.owner});
          if (e.owner) begin
            chk("dm_err", {31'd0, dm_err}, {31'd0, e.err});
            chk("dm_rdata", dm_rdata, e.rdata);
            chk("if_rdata_hold", if_rdata, last_if_rdata);
            last_dm_rdata = e.rdata;
          end else begin
            chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            chk("if_rdata", if_rdata, e.rdata);
            chk("dm_rdata_hold", dm_rdata, last_dm_rdata);
            last_if_rdata = e.rdata;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    stage0_v = 1'b0;
    stage0 = '0;
    last_if_rdata = 32'd0;
    last_dm_rdata = 32'd0;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    dm_req = 1'b0; dm_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // 1: single IF fetch of word 2
    cycle(1'b1, 32'h8, 1'b0, 32'd0, 1'b0, EXP_IF);
    idle(3);

    // 2: both held, IF wins every fourth contested cycle
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_IF);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_DM);
    cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, EXP_IF);
    idle(3);

    // 3: misaligned then out-of-range DM loads, back to back
    cycle(1'b0, 32'd0, 1'b1, 32'h6, 1'b0, EXP_DM);
    cycle(1'b0, 32'd0, 1'b1, 32'h200, 1'b0, EXP_DM);
    idle(3);

    // 4: flush kills IF@0x4; IF@0x8 granted in the flush cycle survives
    cycle(1'b1, 32'h4, 1'b0, 32'd0, 1'b0, EXP_IF);
    cycle(1'b1, 32'h8, 1'b0, 32'd0, 1'b1, EXP_IF);
    idle(3);

    // 5: build up starve count, reset with a DM access in flight
    cycle(1'b1, 32'h24, 1'b1, 32'h28, 1'b0, EXP_DM);
    cycle(1'b1, 32'h24, 1'b1, 32'h2C, 1'b0, EXP_DM);
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    stage0_v = 1'b0;
    last_if_rdata = 32'd0;
    last_dm_rdata = 32'd0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    cycle(1'b1, 32'h30, 1'b1, 32'h34, 1'b0, EXP_DM);
    cycle(1'b1, 32'h30, 1'b1, 32'h34, 1'b0, EXP_DM);
    cycle(1'b1, 32'h30, 1'b1, 32'h34, 1'b0, EXP_DM);
    cycle(1'b1, 32'h30, 1'b1, 32'h34, 1'b0, EXP_IF);
    idle(3);

    // 6: alternating owners, results in order on consecutive cycles
    cycle(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, EXP_IF);
    cycle(1'b0, 32'd0, 1'b1, 32'h10, 1'b0, EXP_DM);
    cycle(1'b1, 32'h14, 1'b0, 32'd0, 1'b0, EXP_IF);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
